alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_divider.sv | 77 +++++++
 rtl/alu_exec_unit.sv | 182 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU execution unit: opcode enum, flag struct, control FSM states.
package alu_pkg;

  localparam int OP_W    = 4;
  localparam int FLAGS_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_SUB = 4'd0,
    OP_ADD = 4'd1,
    OP_MUL = 4'd2,
    OP_MOV = 4'd3,
    OP_CMP = 4'd4,
    OP_DIV = 4'd5,
    OP_XOR = 4'd6,
    OP_AND = 4'd7,
    OP_NOT = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider: one quotient bit per cycle, N cycles per division.
// done pulses in the last busy cycle while quotient already shows the final value.
module alu_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient
);

  localparam int CNT_W = $clog2(N + 1);

  logic [N-1:0]     rem_q, rem_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [N:0]       shifted;
  logic [N:0]       trial;
  logic [N-1:0]     step_rem;
  logic [N-1:0]     step_quo;

  always_comb begin
    // Remainder stays below the divisor, so the shifted value fits in N+1 bits.
    shifted  = {rem_q, quo_q[N-1]};
    trial    = shifted - {1'b0, dvs_q};
    step_rem = trial[N] ? shifted[N-1:0] : trial[N-1:0];
    step_quo = {quo_q[N-2:0], ~trial[N]};

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    if (busy_q) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
      end
    end else if (start) begin
      rem_d  = '0;
      quo_d  = a;
      dvs_d  = b;
      cnt_d  = CNT_W'(N);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CNT_W'(1));
  assign quotient = step_quo;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops plus an iterative divide, with a one-deep
// registered output held under valid/ready backpressure.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       result,
  output logic [FLAGS_W-1:0] flags,
  output logic               err
);

  alu_state_e   state_q, state_d;
  logic [N-1:0] result_q, result_d;
  alu_flags_t   flags_q, flags_d;
  logic         err_q, err_d;
  logic         out_valid_q, out_valid_d;

  alu_op_e      op_e;
  logic         accept;
  logic         div_start;
  logic         div_busy;
  logic         div_done;
  logic [N-1:0] div_quotient;

  logic [N:0]     sum_w;
  logic [N:0]     diff_w;
  logic [N:0]     shl_w;
  logic [N:0]     shr_w;
  logic [2*N-1:0] prod_w;
  logic [N-1:0]   alu_res;
  logic [N-1:0]   nz_src;
  logic           alu_c;
  logic           alu_v;
  logic           alu_err;
  alu_flags_t     alu_flags;

  assign op_e      = alu_op_e'(op);
  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && (op_e == OP_DIV) && (b != '0);

  alu_divider #(.N(N)) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .a        (a),
    .b        (b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    sum_w  = {1'b0, a} + {1'b0, b};
    diff_w = {1'b0, a} - {1'b0, b};
    prod_w = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    // The extra bit on each shift catches the last bit shifted out.
    shl_w  = {1'b0, a} << b;
    shr_w  = {a, 1'b0} >> b;
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op_e)
      OP_SUB, OP_CMP: begin
        alu_res = (op_e == OP_CMP) ? a : diff_w[N-1:0];
        alu_c   = ~diff_w[N];
        alu_v   = (a[N-1] ^ b[N-1]) & (diff_w[N-1] ^ a[N-1]);
      end
      OP_ADD: begin
        alu_res = sum_w[N-1:0];
        alu_c   = sum_w[N];
        alu_v   = ~(a[N-1] ^ b[N-1]) & (sum_w[N-1] ^ a[N-1]);
      end
      OP_MUL: begin
        alu_res = prod_w[N-1:0];
        alu_c   = |prod_w[2*N-1:N];
        alu_v   = |prod_w[2*N-1:N];
      end
      OP_MOV: alu_res = b;
      OP_DIV: begin
        // Only reaches the output for a zero divisor; nonzero divides go to the divider.
        alu_res = '1;
        alu_v   = 1'b1;
        alu_err = 1'b1;
      end
      OP_XOR: alu_res = a ^ b;
      OP_AND: alu_res = a & b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res = shl_w[N-1:0];
        alu_c   = shl_w[N];
      end
      OP_SHR: begin
        alu_res = shr_w[N:1];
        alu_c   = shr_w[0];
      end
      default: alu_err = 1'b1;
    endcase
    // CMP returns a unchanged but reports N/Z of the difference.
    nz_src    = (op_e == OP_CMP) ? diff_w[N-1:0] : alu_res;
    alu_flags = '{n: nz_src[N-1], z: (nz_src == '0), c: alu_c, v: alu_v};
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (div_start) begin
            state_d     = ST_DIV_BUSY;
            out_valid_d = 1'b0;
          end else begin
            result_d    = alu_res;
            flags_d     = alu_flags;
            err_d       = alu_err;
            out_valid_d = 1'b1;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_DIV_BUSY: begin
        if (div_done) begin
          result_d    = div_quotient;
          flags_d     = '{n: div_quotient[N-1], z: (div_quotient == '0), c: 1'b0, v: 1'b0};
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (!div_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit at N = 8: directed corner cases, divide timing,
// reset abort, back-to-back throughput and randomized ops against an arithmetic model.
module tb_alu_exec_unit;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference: plain integer arithmetic on 8-bit values.
  function automatic void ref_model(input int o, input int x, input int y,
                                    output logic [7:0] r, output logic [3:0] f,
                                    output logic e);
    int t, nz, res;
    logic c, v;
    c = 1'b0; v = 1'b0; e = 1'b0; res = 0; nz = -1;
    case (o)
      0, 4: begin
        t   = x - y;
        res = (t + 256) % 256;
        c   = (x >= y);
        t   = sgn(x) - sgn(y);
        v   = (t > 127) || (t < -128);
        nz  = res;
        if (o == 4) res = x;
      end
      1: begin
        t   = x + y;
        res = t % 256;
        c   = (t > 255);
        t   = sgn(x) + sgn(y);
        v   = (t > 127) || (t < -128);
      end
      2: begin
        t   = x * y;
        res = t % 256;
        c   = (t > 255);
        v   = (t > 255);
      end
      3: res = y;
      5: begin
        if (y == 0) begin
          res = 255; e = 1'b1; v = 1'b1;
        end else begin
          res = x / y;
        end
      end
      6: res = x ^ y;
      7: res = x & y;
      8: res = 255 - x;
      9: begin
        res = (y >= 8) ? 0 : (x * (1 << y)) % 256;
        c   = (y == 0 || y > 8) ? 1'b0 : 1'(((x >> (8 - y)) & 1));
      end
      10: begin
        res = (y >= 8) ? 0 : x / (1 << y);
        c   = (y == 0 || y > 8) ? 1'b0 : 1'(((x >> (y - 1)) & 1));
      end
      default: begin
        res = 0; e = 1'b1;
      end
    endcase
    if (nz < 0) nz = res;
    r = 8'(res);
    f = {nz >= 128, nz == 0, c, v};
  endfunction

  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int w;
    w = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: in_ready=%0b required 1 after %0d cycles", in_ready, w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%0b result=%h flags=%b err=%0b required 0 00 0000 0",
               out_valid, result, flags, err);
    end
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%0b required 1", in_ready);
    end
    $display("txn reset released");
  endtask

  typedef struct {
    logic [3:0] o;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] r;
    logic [3:0] f;
    logic       e;
  } vec_t;

  task automatic test_directed;
    vec_t v[16];
    v[0]  = '{4'd1,  8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0};
    v[1]  = '{4'd0,  8'h80, 8'h01, 8'h7F, 4'b0011, 1'b0};
    v[2]  = '{4'd4,  8'h05, 8'h05, 8'h05, 4'b0110, 1'b0};
    v[3]  = '{4'd5,  8'h37, 8'h00, 8'hFF, 4'b1001, 1'b1};
    v[4]  = '{4'd13, 8'h12, 8'h34, 8'h00, 4'b0100, 1'b1};
    v[5]  = '{4'd9,  8'h81, 8'h01, 8'h02, 4'b0010, 1'b0};
    v[6]  = '{4'd10, 8'h81, 8'h09, 8'h00, 4'b0100, 1'b0};
    v[7]  = '{4'd2,  8'h10, 8'h10, 8'h00, 4'b0111, 1'b0};
    v[8]  = '{4'd8,  8'h0F, 8'h3C, 8'hF0, 4'b1000, 1'b0};
    v[9]  = '{4'd9,  8'h01, 8'h08, 8'h00, 4'b0110, 1'b0};
    v[10] = '{4'd10, 8'h80, 8'h08, 8'h00, 4'b0110, 1'b0};
    v[11] = '{4'd3,  8'h11, 8'hA5, 8'hA5, 4'b1000, 1'b0};
    v[12] = '{4'd6,  8'hF0, 8'hFF, 8'h0F, 4'b0000, 1'b0};
    v[13] = '{4'd7,  8'hF0, 8'h8F, 8'h80, 4'b1000, 1'b0};
    v[14] = '{4'd0,  8'h01, 8'h02, 8'hFF, 4'b1000, 1'b0};
    v[15] = '{4'd1,  8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(v[i].o, v[i].x, v[i].y);
      checks++;
      if (out_valid !== 1'b1 || result !== v[i].r || flags !== v[i].f || err !== v[i].e) begin
        errors++;
        $display("FAIL directed_%0d: valid=%0b result=%h flags=%b err=%0b required 1 %h %b %0b",
                 i, out_valid, result, flags, err, v[i].r, v[i].f, v[i].e);
      end
      $display("txn directed op=%0d a=%h b=%h result=%h flags=%b err=%0b",
               v[i].o, v[i].x, v[i].y, result, flags, err);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_div_timing;
    out_ready = 1'b0;
    send(4'd5, 8'd200, 8'd7);
    // Requests arriving while busy must be ignored.
    op = 4'd1; a = 8'd1; b = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL div_busy_%0d: in_ready=%0b out_valid=%0b required 0 0", i, in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || result !== 8'd28 || flags !== 4'b0000 || err !== 1'b0) begin
      errors++;
      $display("FAIL div_result: valid=%0b result=%0d flags=%b err=%0b required 1 28 0000 0",
               out_valid, result, flags, err);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 8'd28 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL div_hold_%0d: valid=%0b result=%0d in_ready=%0b required 1 28 0",
                 i, out_valid, result, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL div_consume: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
    $display("txn div 200/7 result=28 held 3 cycles");
  endtask

  task automatic test_reset_mid_div;
    out_ready = 1'b1;
    send(4'd1, 8'd1, 8'd2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'd5, 8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: valid=%0b result=%h flags=%b err=%0b required 0 00 0000 0",
               out_valid, result, flags, err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready: in_ready=%0b required 1", in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_result_%0d: out_valid=%0b required 0", i, out_valid);
      end
    end
    out_ready = 1'b1;
    send(4'd1, 8'd3, 8'd4);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'd7 || flags !== 4'b0000 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_then_add: valid=%0b result=%0d flags=%b err=%0b required 1 7 0000 0",
               out_valid, result, flags, err);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("txn reset mid-divide then add 3+4 result=%0d", result);
  endtask

  task automatic test_back_to_back;
    logic [3:0] o;
    logic [7:0] x, y, er;
    logic [3:0] ef;
    logic       ee;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      o = 4'($urandom_range(0, 15));
      if (o == 4'd5) o = 4'd1;
      x = 8'($urandom); y = 8'($urandom_range(0, 255));
      op = o; a = x; b = y; in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: in_ready=%0b required 1", i, in_ready);
      end
      ref_model(int'(o), int'(x), int'(y), er, ef, ee);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== er || flags !== ef || err !== ee) begin
        errors++;
        $display("FAIL b2b_%0d: op=%0d a=%h b=%h valid=%0b result=%h flags=%b err=%0b required 1 %h %b %0b",
                 i, o, x, y, out_valid, result, flags, err, er, ef, ee);
      end
      $display("txn b2b op=%0d a=%h b=%h result=%h flags=%b err=%0b", o, x, y, result, flags, err);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%0b required 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [3:0] o;
    logic [7:0] x, y, er;
    logic [3:0] ef;
    logic       ee;
    int         w, lat, hold;
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      x = 8'($urandom);
      y = 8'($urandom);
      if ($urandom_range(0, 3) == 0) y = 8'($urandom_range(0, 9));
      ref_model(int'(o), int'(x), int'(y), er, ef, ee);
      lat = (o == 4'd5 && y != 8'd0) ? N : 0;
      out_ready = 1'b0;
      send(o, x, y);
      w = 0;
      while (!out_valid && w < 40) begin
        @(posedge clk); #1;
        w++;
      end
      checks++;
      if (w != lat) begin
        errors++;
        $display("FAIL rand_latency_%0d: op=%0d waited=%0d required %0d", i, o, w, lat);
      end
      checks++;
      if (out_valid !== 1'b1 || result !== er || flags !== ef || err !== ee) begin
        errors++;
        $display("FAIL rand_%0d: op=%0d a=%h b=%h result=%h flags=%b err=%0b required %h %b %0b",
                 i, o, x, y, result, flags, err, er, ef, ee);
      end
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || result !== er || flags !== ef || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL rand_hold_%0d: valid=%0b result=%h flags=%b in_ready=%0b required 1 %h %b 0",
                   i, out_valid, result, flags, in_ready, er, ef);
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_consume_%0d: out_valid=%0b required 0", i, out_valid);
      end
      $display("txn rand op=%0d a=%h b=%h result=%h flags=%b err=%0b", o, x, y, er, ef, ee);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_div_timing();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
